// File: rtl/fetch_ctrl_if.sv
// Fetch-side bundle between fetch_ctrl, the combinational instruction ROM,
// the redirect source and the decode stage.
interface fetch_ctrl_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic [ADDRESS_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0]    imem_instr;
    logic                     halt_req;
    logic                     redirect_valid;
    logic [ADDRESS_WIDTH-1:0] redirect_pc;
    logic                     instr_valid;
    logic                     instr_ready;
    logic [DATA_WIDTH-1:0]    instr_out;
    logic [ADDRESS_WIDTH-1:0] pc_out;
    logic [31:0]              retired_cnt;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  halt_req,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr_out,
        output pc_out,
        output retired_cnt
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output halt_req,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr_out,
        input  pc_out,
        input  retired_cnt
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC register, IDLE/FETCH/HALT sequencing and a
// two-entry {pc, instr} buffer feeding decode, with redirect flush.
module fetch_ctrl #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t                   state_r;
    logic [ADDRESS_WIDTH-1:0] fetch_pc_r,    fetch_pc_s;
    logic [1:0]               count_r,       count_s;
    logic                     valid_r,       valid_s;
    logic [ADDRESS_WIDTH-1:0] slot0_pc_r,    slot0_pc_s;
    logic [DATA_WIDTH-1:0]    slot0_instr_r, slot0_instr_s;
    logic [ADDRESS_WIDTH-1:0] slot1_pc_r,    slot1_pc_s;
    logic [DATA_WIDTH-1:0]    slot1_instr_r, slot1_instr_s;
    logic [31:0]              retired_r;
    logic                     pop_s;
    logic                     push_s;

    function automatic logic [ADDRESS_WIDTH-1:0] word_align(input logic [ADDRESS_WIDTH-1:0] addr);
        return {addr[ADDRESS_WIDTH-1:2], 2'b00};
    endfunction

    // Next-state datapath: buffer shift/fill, PC advance and redirect flush.
    // Slot 0 is always the head; vacated slots are zeroed so the head
    // registers read as zero whenever the buffer is empty.
    always_comb begin
        pop_s         = valid_r && bus.instr_ready;
        push_s        = (state_r == FETCH) && !bus.halt_req && !bus.redirect_valid &&
                        ((count_r != 2'd2) || pop_s);
        fetch_pc_s    = fetch_pc_r;
        count_s       = count_r;
        slot0_pc_s    = slot0_pc_r;
        slot0_instr_s = slot0_instr_r;
        slot1_pc_s    = slot1_pc_r;
        slot1_instr_s = slot1_instr_r;
        if (bus.redirect_valid) begin
            fetch_pc_s    = word_align(bus.redirect_pc);
            count_s       = 2'd0;
            slot0_pc_s    = {ADDRESS_WIDTH{1'b0}};
            slot0_instr_s = {DATA_WIDTH{1'b0}};
            slot1_pc_s    = {ADDRESS_WIDTH{1'b0}};
            slot1_instr_s = {DATA_WIDTH{1'b0}};
        end else begin
            if (push_s) begin
                fetch_pc_s = fetch_pc_r + ADDRESS_WIDTH'(3'd4);
            end else begin
                fetch_pc_s = fetch_pc_r;
            end
            case ({pop_s, push_s})
                2'b11: begin
                    if (count_r == 2'd2) begin
                        slot0_pc_s    = slot1_pc_r;
                        slot0_instr_s = slot1_instr_r;
                        slot1_pc_s    = fetch_pc_r;
                        slot1_instr_s = bus.imem_instr;
                    end else begin
                        slot0_pc_s    = fetch_pc_r;
                        slot0_instr_s = bus.imem_instr;
                    end
                end
                2'b10: begin
                    slot0_pc_s    = slot1_pc_r;
                    slot0_instr_s = slot1_instr_r;
                    slot1_pc_s    = {ADDRESS_WIDTH{1'b0}};
                    slot1_instr_s = {DATA_WIDTH{1'b0}};
                    count_s       = count_r - 2'd1;
                end
                2'b01: begin
                    if (count_r == 2'd0) begin
                        slot0_pc_s    = fetch_pc_r;
                        slot0_instr_s = bus.imem_instr;
                    end else begin
                        slot1_pc_s    = fetch_pc_r;
                        slot1_instr_s = bus.imem_instr;
                    end
                    count_s = count_r + 2'd1;
                end
                default: begin
                    count_s = count_r;
                end
            endcase
        end
        valid_s = (count_s != 2'd0);
    end

    // State register, sequencing FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            fetch_pc_r    <= RESET_PC;
            count_r       <= 2'd0;
            valid_r       <= 1'b0;
            slot0_pc_r    <= {ADDRESS_WIDTH{1'b0}};
            slot0_instr_r <= {DATA_WIDTH{1'b0}};
            slot1_pc_r    <= {ADDRESS_WIDTH{1'b0}};
            slot1_instr_r <= {DATA_WIDTH{1'b0}};
            retired_r     <= 32'd0;
        end else begin
            case (state_r)
                IDLE:    state_r <= bus.halt_req ? HALT : FETCH;
                FETCH:   state_r <= bus.halt_req ? HALT : FETCH;
                HALT:    state_r <= bus.halt_req ? HALT : FETCH;
                default: state_r <= IDLE;
            endcase
            fetch_pc_r    <= fetch_pc_s;
            count_r       <= count_s;
            valid_r       <= valid_s;
            slot0_pc_r    <= slot0_pc_s;
            slot0_instr_r <= slot0_instr_s;
            slot1_pc_r    <= slot1_pc_s;
            slot1_instr_r <= slot1_instr_s;
            retired_r     <= retired_r + {31'd0, pop_s};
        end
    end

    assign bus.imem_addr   = fetch_pc_r;
    assign bus.instr_valid = valid_r;
    assign bus.instr_out   = slot0_instr_r;
    assign bus.pc_out      = slot0_pc_r;
    assign bus.retired_cnt = retired_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random traffic, all checked
// against a queue-based behavioural model of the fetch buffer.
module tb_fetch_ctrl;
    localparam int          AW     = 32;
    localparam int          DW     = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_ctrl_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fetch_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ROM word n holds the value n.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction
    assign bus.imem_instr = rom(bus.imem_addr);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    bit          m_prev_halt;
    bit          m_fresh;
    int          pass_cnt  = 0;
    int          total_cnt = 0;

    wire logic [128:0] dut_vec = {bus.instr_valid, bus.pc_out, bus.instr_out, bus.retired_cnt, bus.imem_addr};

    function automatic logic [128:0] exp_vec();
        if (m_q.size() == 0) return {1'b0, 64'd0, m_ret, m_pc};
        else                 return {1'b1, m_q[0].pc, m_q[0].instr, m_ret, m_pc};
    endfunction

    // Fetching is enabled once a cycle has passed since reset and halt_req
    // was low on the previous cycle.
    task automatic tick();
        bit pop, push, fen;
        if (!rst_n) begin
            m_q.delete();
            m_pc        = RST_PC;
            m_ret       = 32'd0;
            m_fresh     = 1'b1;
            m_prev_halt = 1'b0;
        end else begin
            pop  = (m_q.size() != 0) && bus.instr_ready;
            fen  = !m_fresh && !m_prev_halt;
            push = fen && !bus.halt_req && !bus.redirect_valid && ((m_q.size() < 2) || pop);
            if (pop) m_ret = m_ret + 32'd1;
            if (bus.redirect_valid) begin
                m_q.delete();
                m_pc = {bus.redirect_pc[31:2], 2'b00};
            end else begin
                if (pop) void'(m_q.pop_front());
                if (push) begin
                    m_q.push_back({m_pc, rom(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
            m_prev_halt = bus.halt_req;
            m_fresh     = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total_cnt++;
        if (dut_vec !== {1'b0, 96'd0, RST_PC}) $display("FAIL reset_state got=%h exp=%h", dut_vec, {1'b0, 96'd0, RST_PC});
        else pass_cnt++;
    endtask

    task automatic test_sequential();
        bus.instr_ready = 1'b1;
        bus.halt_req    = 1'b0;
        rst_n           = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            total_cnt++;
            if (dut_vec !== exp_vec()) $display("FAIL seq_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            else pass_cnt++;
            if (i >= 2) begin
                total_cnt++;
                if ({bus.instr_valid, bus.pc_out, bus.instr_out} !== {1'b1, 32'(4 * (i - 2)), 32'(i - 2)})
                    $display("FAIL seq_head cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                             i, bus.pc_out, bus.instr_out, 32'(4 * (i - 2)), 32'(i - 2));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_backpressure();
        rst_n = 1'b0;
        tick();
        rst_n           = 1'b1;
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        total_cnt++;
        if ({bus.instr_valid, bus.imem_addr, bus.pc_out} !== {1'b1, 32'h8, 32'h0})
            $display("FAIL bp_saturate got valid=%b addr=%h pc=%h exp valid=1 addr=8 pc=0", bus.instr_valid, bus.imem_addr, bus.pc_out);
        else pass_cnt++;
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            total_cnt++;
            if ({bus.instr_valid, bus.pc_out} !== {1'b1, 32'(4 * k)})
                $display("FAIL bp_order k=%0d got pc=%h exp=%h", k, bus.pc_out, 32'(4 * k));
            else pass_cnt++;
            tick();
            total_cnt++;
            if (dut_vec !== exp_vec()) $display("FAIL bp_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
            else pass_cnt++;
        end
        bus.instr_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_redirect();
        logic [31:0] ret0;
        ret0               = m_ret;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0103;
        bus.instr_ready    = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        bus.instr_ready    = 1'b0;
        total_cnt++;
        if ({bus.instr_valid, bus.imem_addr, bus.retired_cnt} !== {1'b0, 32'h100, ret0 + 32'd1})
            $display("FAIL redir_flush got valid=%b addr=%h ret=%0d exp valid=0 addr=100 ret=%0d",
                     bus.instr_valid, bus.imem_addr, bus.retired_cnt, ret0 + 32'd1);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({bus.instr_valid, bus.pc_out, bus.instr_out} !== {1'b1, 32'h100, 32'h40})
            $display("FAIL redir_target got pc=%h instr=%h exp pc=100 instr=40", bus.pc_out, bus.instr_out);
        else pass_cnt++;
        total_cnt++;
        if (dut_vec !== exp_vec()) $display("FAIL redir_model got=%h exp=%h", dut_vec, exp_vec());
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8;
        exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFF8;
        bus.instr_ready    = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            total_cnt++;
            if ({bus.instr_valid, bus.pc_out} !== {1'b1, exp_pc[k]})
                $display("FAIL wrap_seq k=%0d got pc=%h exp=%h", k, bus.pc_out, exp_pc[k]);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (dut_vec !== exp_vec()) $display("FAIL wrap_model got=%h exp=%h", dut_vec, exp_vec());
        else pass_cnt++;
    endtask

    task automatic test_halt();
        logic [31:0] pc_hold, ret0;
        bus.instr_ready = 1'b0;
        tick();
        tick();
        tick();
        pc_hold         = m_pc;
        ret0            = m_ret;
        bus.halt_req    = 1'b1;
        bus.instr_ready = 1'b1;
        tick();
        tick();
        tick();
        total_cnt++;
        if ({bus.instr_valid, bus.retired_cnt, bus.imem_addr} !== {1'b0, ret0 + 32'd2, pc_hold})
            $display("FAIL halt_drain got valid=%b ret=%0d addr=%h exp valid=0 ret=%0d addr=%h",
                     bus.instr_valid, bus.retired_cnt, bus.imem_addr, ret0 + 32'd2, pc_hold);
        else pass_cnt++;
        bus.halt_req = 1'b0;
        tick();
        tick();
        total_cnt++;
        if ({bus.instr_valid, bus.pc_out} !== {1'b1, pc_hold})
            $display("FAIL halt_resume got valid=%b pc=%h exp valid=1 pc=%h", bus.instr_valid, bus.pc_out, pc_hold);
        else pass_cnt++;
        total_cnt++;
        if (dut_vec !== exp_vec()) $display("FAIL halt_model got=%h exp=%h", dut_vec, exp_vec());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bus.instr_ready = 1'b0;
        tick();
        tick();
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        tick();
        total_cnt++;
        if (dut_vec !== {1'b0, 96'd0, RST_PC}) $display("FAIL reset_mid got=%h exp=%h", dut_vec, {1'b0, 96'd0, RST_PC});
        else pass_cnt++;
        rst_n              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.instr_ready    = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        total_cnt++;
        if (dut_vec !== exp_vec()) $display("FAIL reset_mid_model got=%h exp=%h", dut_vec, exp_vec());
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst_n              = ($urandom % 97) != 0;
            bus.halt_req       = ($urandom % 4) == 0;
            bus.redirect_valid = ($urandom % 10) == 0;
            bus.redirect_pc    = $urandom;
            bus.instr_ready    = ($urandom % 3) != 0;
            tick();
            total_cnt++;
            if (dut_vec !== exp_vec()) $display("FAIL rand_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            else pass_cnt++;
        end
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.halt_req       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.instr_ready    = 1'b0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_halt();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1);
    end
endmodule
